// File: rtl/pika_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package pika_loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream LSB-first into 32-bit words and emits a one-cycle
// word-valid pulse together with the completed word.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic        word_valid_q;
    logic [31:0] word_q;

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    assign shift_d = {byte_i, shift_q[31:8]};

    // Byte index, shift register and registered word/pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q        <= 2'd0;
            shift_q      <= 32'd0;
            word_valid_q <= 1'b0;
            word_q       <= 32'd0;
        end else begin
            word_valid_q <= 1'b0;
            if (clr_i) begin
                idx_q   <= 2'd0;
                shift_q <= 32'd0;
                word_q  <= 32'd0;
            end else if (byte_valid_i) begin
                shift_q <= shift_d;
                idx_q   <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_valid_q <= 1'b1;
                    word_q       <= shift_d;
                end
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: LEN_LO, LEN_HI, 4N payload bytes, CHK.
// Writes words to instruction memory and holds the core until a good image.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN_LO | accepting low length byte
//   LEN_HI | accepting high length byte, validating N
//   DATA   | accepting 4N payload bytes
//   CHECK  | accepting and comparing checksum byte
//   DONE   | good image loaded, core released
//   ERROR  | bad length or checksum, core held
module imem_loader
    import pika_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);

    state_t              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic [LEN_W+1:0]    byte_cnt_q;
    logic [LEN_W+1:0]    last_idx;
    logic [LEN_W-1:0]    wcnt_q;
    logic [7:0]          chk_q;
    logic                rx_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                cpu_hold_q;
    logic [1:0]          err_q;
    logic [ADDR_W-1:0]   waddr_q;

    logic accept;
    logic start_ok;
    logic len_bad;

    assign accept   = rx_valid && rx_ready_q;
    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign len_d    = {rx_data, len_q[7:0]};
    assign len_bad  = (len_d == '0) || ({1'b0, len_d} > (LEN_W+1)'(DEPTH));
    assign last_idx = {len_q, 2'b00} - (LEN_W+2)'(1);

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (start_ok),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (rx_data),
        .word_valid_o (imem_we),
        .word_o       (imem_wdata)
    );

    // Frame sequencing, counters, checksum and all registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            wcnt_q     <= '0;
            chk_q      <= 8'd0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            err_q      <= ERR_NONE;
            waddr_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= LEN_LO;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= ERR_NONE;
                        chk_q      <= 8'd0;
                        byte_cnt_q <= '0;
                        wcnt_q     <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q   <= {len_q[LEN_W-1:8], rx_data};
                        state_q <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (len_bad) begin
                            state_q    <= ERROR;
                            err_q      <= ERR_LEN;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk_q      <= chk_q ^ rx_data;
                        byte_cnt_q <= byte_cnt_q + (LEN_W+2)'(1);
                        if (byte_cnt_q[1:0] == 2'b11) begin
                            waddr_q <= wcnt_q[ADDR_W-1:0];
                            wcnt_q  <= wcnt_q + LEN_W'(1);
                        end
                        if (byte_cnt_q == last_idx) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data == chk_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= ERR_CHK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_waddr = waddr_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames with random payloads, a write
// recorder compared against the intended image, plus a reset-abort sequence.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wr_q[$];

    logic [31:0] words [0:DEPTH-1];

    typedef struct {
        int         n;          // length field sent
        int         chk_mode;   // >=0 literal CHK, -1 correct, -2 corrupted
        int         gap_mode;   // 0 back-to-back, 1 random gaps
        int         start_at;   // payload byte index carrying a stray start, -1 none
        logic [1:0] exp_err;
        logic       exp_done;
    } vec_t;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back('{int'(imem_waddr), imem_wdata, cyc});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one byte after an optional idle gap; wait (bounded) until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = st;
        for (int k = 0; k < 50; k++) begin
            if (rx_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end else begin
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_start;
        wr_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rx_ready", rx_ready, 1);
        chk("start_cpu_hold", cpu_hold, 1);
        chk("start_done", done, 0);
        chk("start_err", err_code, 0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [15:0] n16;
        logic [7:0]  x;
        logic [7:0]  by;
        logic [7:0]  cb;
        int          nb;
        int          bad;
        int          first;
        int          sp_bad;
        n16 = 16'(v.n);
        do_start();
        send_byte(n16[7:0], 0, 1'b0);
        send_byte(n16[15:8], 0, 1'b0);
        if (v.n == 0 || v.n > DEPTH) begin
            chk("badlen_err", err_code, v.exp_err);
            chk("badlen_rx_ready", rx_ready, 0);
            chk("badlen_busy", busy, 0);
            chk("badlen_cpu_hold", cpu_hold, 1);
            chk("badlen_done", done, 0);
            repeat (4) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b0;
            chk("badlen_no_writes", wr_q.size(), 0);
            chk("badlen_err_held", err_code, v.exp_err);
        end else begin
            x  = 8'd0;
            nb = 0;
            for (int w = 0; w < v.n; w++) begin
                for (int b = 0; b < 4; b++) begin
                    by = words[w][8*b +: 8];
                    x  = x ^ by;
                    send_byte(by, (v.gap_mode != 0) ? int'($urandom_range(0, 1)) : 0,
                              nb == v.start_at);
                    nb++;
                end
            end
            if (v.chk_mode >= 0)       cb = 8'(v.chk_mode);
            else if (v.chk_mode == -1) cb = x;
            else                       cb = x ^ 8'h5A;
            send_byte(cb, (v.gap_mode != 0) ? int'($urandom_range(0, 1)) : 0, 1'b0);
            chk("end_done", done, v.exp_done);
            chk("end_err", err_code, v.exp_err);
            chk("end_cpu_hold", cpu_hold, !v.exp_done);
            chk("end_busy", busy, 0);
            chk("end_rx_ready", rx_ready, 0);
            chk("wr_count", wr_q.size(), v.n);
            bad   = 0;
            first = -1;
            for (int i = 0; i < v.n && i < wr_q.size(); i++) begin
                if (wr_q[i].addr != i || wr_q[i].data !== words[i]) begin
                    if (bad == 0) first = i;
                    bad++;
                end
            end
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL wr_content: %0d bad words, first index %0d got addr %0d data 0x%h, expected addr %0d data 0x%h",
                         bad, first, wr_q[first].addr, wr_q[first].data, first, words[first]);
            end
            if (v.gap_mode == 0 && v.n > 1) begin
                sp_bad = 0;
                for (int i = 1; i < wr_q.size(); i++)
                    if (wr_q[i].cyc - wr_q[i-1].cyc != 4) sp_bad++;
                chk("wr_spacing_violations", sp_bad, 0);
            end
        end
    endtask

    vec_t tbl [10];

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        tbl[0] = '{2,   8'h7C, 0, -1, 2'd0, 1'b1};
        tbl[1] = '{2,   8'h00, 0, -1, 2'd2, 1'b0};
        tbl[2] = '{2,   -1,    0, -1, 2'd0, 1'b1};
        tbl[3] = '{0,   -1,    0, -1, 2'd1, 1'b0};
        tbl[4] = '{257, -1,    0, -1, 2'd1, 1'b0};
        tbl[5] = '{1,   -1,    1, -1, 2'd0, 1'b1};
        tbl[6] = '{5,   -2,    1, -1, 2'd2, 1'b0};
        tbl[7] = '{256, -1,    1, -1, 2'd0, 1'b1};
        tbl[8] = '{256, -1,    0, -1, 2'd0, 1'b1};
        tbl[9] = '{3,   -1,    0,  5, 2'd0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_waddr", imem_waddr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_code, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_rx_ready", rx_ready, 0);

        for (int t = 0; t < 10; t++) begin
            if (t < 2) begin
                words[0] = 32'h0000_0013;
                words[1] = 32'h0000_006F;
            end else begin
                for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
            end
            run_frame(tbl[t]);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset asserted together with the 8th payload byte: pending write must vanish.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        do_start();
        send_byte(8'd2, 0, 1'b0);
        send_byte(8'd0, 0, 1'b0);
        for (int b = 0; b < 7; b++) send_byte(words[b/4][8*(b%4) +: 8], 0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = words[1][31:24];
        reset    = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_cpu_hold", cpu_hold, 1);
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_imem_we", imem_we, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_code, 0);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_write_count", wr_q.size(), 1);
        if (wr_q.size() >= 1) begin
            chk("abort_w0_addr", wr_q[0].addr, 0);
            chk("abort_w0_data", wr_q[0].data, words[0]);
        end
        chk("abort_idle_rx_ready", rx_ready, 0);
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        run_frame('{4, -1, 0, -1, 2'd0, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
